// File: rtl/lfu_finder.sv
// Least-frequently-used victim finder for a 4-entry buffer pool.
// Define LFU_AGING_EN to halve every counter when a saturated counter is referenced.
module lfu_finder #(
    parameter int CNT_W = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       new_buf_req,
    input  logic [1:0] ref_buf_numbr,
    output logic [1:0] buf_num_replc
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]   access_time_0;
    logic [CNT_W-1:0]   access_time_1;
    logic [CNT_W-1:0]   access_time_2;
    logic [CNT_W-1:0]   access_time_3;
    logic [4*CNT_W-1:0] flag;
    logic [CNT_W-1:0]   cnt [4];
    logic [CNT_W-1:0]   nxt [4];
    logic [CNT_W-1:0]   min_val;
    logic [1:0]         n_buf_num_replc;

    assign cnt[0] = access_time_0;
    assign cnt[1] = access_time_1;
    assign cnt[2] = access_time_2;
    assign cnt[3] = access_time_3;
    assign flag   = {access_time_3, access_time_2, access_time_1, access_time_0};

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        min_val         = cnt[0];
        n_buf_num_replc = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (cnt[i] < min_val) begin
                min_val         = cnt[i];
                n_buf_num_replc = 2'(i);
            end
        end
        if (&flag) begin
            n_buf_num_replc = 2'd0;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            nxt[i] = cnt[i];
        end
        if (new_buf_req) begin
            nxt[n_buf_num_replc] = '0;
        end else if (cnt[ref_buf_numbr] == CNT_MAX) begin
`ifdef LFU_AGING_EN
            for (int i = 0; i < 4; i++) begin
                nxt[i] = cnt[i] >> 1;
            end
            nxt[ref_buf_numbr] = (cnt[ref_buf_numbr] >> 1) + CNT_W'(1);
`endif
        end else begin
            nxt[ref_buf_numbr] = cnt[ref_buf_numbr] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            access_time_0 <= '0;
            access_time_1 <= '0;
            access_time_2 <= '0;
            access_time_3 <= '0;
            buf_num_replc <= 2'd0;
        end else begin
            access_time_0 <= nxt[0];
            access_time_1 <= nxt[1];
            access_time_2 <= nxt[2];
            access_time_3 <= nxt[3];
            if (new_buf_req) begin
                buf_num_replc <= n_buf_num_replc;
            end
        end
    end

endmodule

// File: tb/tb_lfu_finder.sv
// Scoreboard bench for lfu_finder: stimulus pushes expected post-edge state,
// a monitor pops and compares counters and victim after every clock edge.
module tb_lfu_finder;

    logic       clk;
    logic       rst_n;
    logic       new_buf_req;
    logic [1:0] ref_buf_numbr;
    logic [1:0] buf_num_replc;

    typedef struct {
        logic [7:0] cnt;
        logic [1:0] victim;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    lfu_finder #(.CNT_W(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .new_buf_req   (new_buf_req),
        .ref_buf_numbr (ref_buf_numbr),
        .buf_num_replc (buf_num_replc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] dutCounters();
        return {dut.access_time_3, dut.access_time_2, dut.access_time_1, dut.access_time_0};
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %02h, expected %02h at %0t", name, actual, expected, $time);
        end
    endtask

    // Called at a falling edge: drive, queue the expected result, let one rising edge pass.
    task automatic applyStimulus(input logic req, input logic [1:0] ref_idx,
                                 input logic [7:0] exp_cnt, input logic [1:0] exp_victim,
                                 input string tag);
        exp_t e;
        new_buf_req   = req;
        ref_buf_numbr = ref_idx;
        e.cnt    = exp_cnt;
        e.victim = exp_victim;
        e.tag    = tag;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asserts reset between edges and checks it took effect without a clock.
    task automatic resetDut(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput({tag, "_cnt"}, dutCounters(), 8'h00);
        checkOutput({tag, "_victim"}, {6'd0, buf_num_replc}, 8'h00);
        new_buf_req   = 1'b0;
        ref_buf_numbr = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput({e.tag, "_cnt"}, dutCounters(), e.cnt);
            checkOutput({e.tag, "_victim"}, {6'd0, buf_num_replc}, {6'd0, e.victim});
        end
    end

    initial begin
        rst_n         = 1'b0;
        new_buf_req   = 1'b0;
        ref_buf_numbr = 2'd0;
        @(negedge clk);
        checkOutput("por_cnt", dutCounters(), 8'h00);
        checkOutput("por_victim", {6'd0, buf_num_replc}, 8'h00);
        rst_n = 1'b1;

        $display("[TB] counting and saturation on buffer 0");
        applyStimulus(1'b0, 2'd0, 8'h01, 2'd0, "ref0_a");
        applyStimulus(1'b0, 2'd0, 8'h02, 2'd0, "ref0_b");
        applyStimulus(1'b0, 2'd0, 8'h03, 2'd0, "ref0_c");
`ifdef LFU_AGING_EN
        applyStimulus(1'b0, 2'd0, 8'h02, 2'd0, "ref0_age");
`else
        applyStimulus(1'b0, 2'd0, 8'h03, 2'd0, "ref0_sat");
`endif
        applyStimulus(1'b0, 2'd0, 8'h03, 2'd0, "ref0_e");

        $display("[TB] round-robin victims");
        resetDut("rst_a");
        applyStimulus(1'b0, 2'd0, 8'h01, 2'd0, "rr_r0a");
        applyStimulus(1'b0, 2'd0, 8'h02, 2'd0, "rr_r0b");
        applyStimulus(1'b1, 2'd0, 8'h02, 2'd1, "rr_req1");
        applyStimulus(1'b0, 2'd1, 8'h06, 2'd1, "rr_r1a");
        applyStimulus(1'b0, 2'd1, 8'h0A, 2'd1, "rr_r1b");
        applyStimulus(1'b1, 2'd1, 8'h0A, 2'd2, "rr_req2");
        applyStimulus(1'b0, 2'd2, 8'h1A, 2'd2, "rr_r2a");
        applyStimulus(1'b0, 2'd2, 8'h2A, 2'd2, "rr_r2b");
        applyStimulus(1'b1, 2'd2, 8'h2A, 2'd3, "rr_req3");
        applyStimulus(1'b0, 2'd3, 8'h6A, 2'd3, "rr_r3a");
        applyStimulus(1'b0, 2'd3, 8'hAA, 2'd3, "rr_r3b");
        applyStimulus(1'b1, 2'd3, 8'hA8, 2'd0, "rr_tie");

        $display("[TB] mixed counters, held request, mid-run reset");
        resetDut("rst_b");
        applyStimulus(1'b0, 2'd0, 8'h01, 2'd0, "mx_0");
        applyStimulus(1'b0, 2'd0, 8'h02, 2'd0, "mx_1");
        applyStimulus(1'b0, 2'd0, 8'h03, 2'd0, "mx_2");
        applyStimulus(1'b0, 2'd1, 8'h07, 2'd0, "mx_3");
        applyStimulus(1'b0, 2'd1, 8'h0B, 2'd0, "mx_4");
        applyStimulus(1'b0, 2'd2, 8'h1B, 2'd0, "mx_5");
        applyStimulus(1'b0, 2'd2, 8'h2B, 2'd0, "mx_6");
        applyStimulus(1'b0, 2'd2, 8'h3B, 2'd0, "mx_7");
        applyStimulus(1'b0, 2'd3, 8'h7B, 2'd0, "mx_8");
        applyStimulus(1'b1, 2'd0, 8'h3B, 2'd3, "mx_req");
        applyStimulus(1'b1, 2'd1, 8'h3B, 2'd3, "mx_hold");
        resetDut("rst_mid");

        $display("[TB] all counters saturated");
        applyStimulus(1'b0, 2'd0, 8'h01, 2'd0, "st_0");
        applyStimulus(1'b0, 2'd0, 8'h02, 2'd0, "st_1");
        applyStimulus(1'b0, 2'd0, 8'h03, 2'd0, "st_2");
        applyStimulus(1'b0, 2'd1, 8'h07, 2'd0, "st_3");
        applyStimulus(1'b0, 2'd1, 8'h0B, 2'd0, "st_4");
        applyStimulus(1'b0, 2'd1, 8'h0F, 2'd0, "st_5");
        applyStimulus(1'b1, 2'd2, 8'h0F, 2'd2, "st_req2");
        applyStimulus(1'b0, 2'd2, 8'h1F, 2'd2, "st_6");
        applyStimulus(1'b0, 2'd2, 8'h2F, 2'd2, "st_7");
        applyStimulus(1'b0, 2'd2, 8'h3F, 2'd2, "st_8");
        applyStimulus(1'b0, 2'd3, 8'h7F, 2'd2, "st_9");
        applyStimulus(1'b0, 2'd3, 8'hBF, 2'd2, "st_10");
        applyStimulus(1'b0, 2'd3, 8'hFF, 2'd2, "st_11");
        checkOutput("flag_full", dut.flag, 8'hFF);
        applyStimulus(1'b1, 2'd3, 8'hFC, 2'd0, "st_req0");
        new_buf_req = 1'b0;

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
